// File: rtl/gb_sound_regs.sv
// gb_sound_regs: GB sound CPU register bank (FF10-FF3F); clock/reset, addr/wr/rd/data_in bus in, data_out registered read, ch_active status in, regs_out/wave_out stored state, trig/power_on pulses out
module gb_sound_regs #(
  parameter logic [127:0] WAVE_INIT = 128'h0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [5:0]   addr,
  input  logic         wr,
  input  logic         rd,
  input  logic [7:0]   data_in,
  output logic [7:0]   data_out,
  input  logic [3:0]   ch_active,
  output logic [183:0] regs_out,
  output logic [127:0] wave_out,
  output logic [3:0]   trig,
  output logic         power_on
);
  localparam logic [183:0] MASK = 184'h70_00_00_BF_00_00_FF_FF_BF_FF_9F_FF_7F_BF_FF_00_3F_FF_BF_FF_00_3F_80;
  logic [7:0]   r [0:21];
  logic         power;
  logic [127:0] wave;
  logic [7:0]   rv;
  logic         reg_wr;
  logic         wave_sel;
  assign wave_sel = addr[5:4] == 2'b10;
  assign reg_wr = wr && power && addr < 6'h16 && addr != 6'h05 && addr != 6'h0F;
  assign wave_out = wave;
  always_comb
    rv = addr < 6'h16 ? ((power ? r[addr[4:0]] : 8'h00) | MASK[8*addr[4:0] +: 8]) :
         addr == 6'h16 ? {power, 3'b111, ch_active & {4{power}}} :
         wave_sel ? wave[8*addr[3:0] +: 8] : 8'hFF;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 22; k++) r[k] <= 8'h00;
      power    <= 1'b0;
      wave     <= WAVE_INIT;
      data_out <= 8'h00;
      trig     <= 4'h0;
      power_on <= 1'b0;
    end else begin
      trig     <= reg_wr ? {addr == 6'h13, addr == 6'h0E, addr == 6'h09, addr == 6'h04} & {4{data_in[7]}} : 4'h0;
      power_on <= wr && addr == 6'h16 && data_in[7] && !power;
      if (rd) data_out <= rv;
      if (reg_wr) r[addr[4:0]] <= data_in;
      if (wr && addr == 6'h16) begin
        power <= data_in[7];
        if (!data_in[7]) for (int k = 0; k < 22; k++) r[k] <= 8'h00;
      end
      if (wr && wave_sel) wave[8*addr[3:0] +: 8] <= data_in;
    end
  end
  for (genvar i = 0; i < 22; i++) begin : g_out
    assign regs_out[8*i +: 8] = power ? r[i] : 8'h00;
  end
  assign regs_out[183:176] = {power, 7'h00};
endmodule

// File: tb/tb_gb_sound_regs.sv
// tb_gb_sound_regs: randomized and directed check of gb_sound_regs against a register-map reference model
module tb_gb_sound_regs;
  localparam logic [127:0] WINIT = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   addr = '0;
  logic         wr = 1'b0;
  logic         rd = 1'b0;
  logic [7:0]   data_in = '0;
  logic [7:0]   data_out;
  logic [3:0]   ch_active = '0;
  logic [183:0] regs_out;
  logic [127:0] wave_out;
  logic [3:0]   trig;
  logic         power_on;
  int checks = 0;
  int errors = 0;
  logic [7:0] m [22];
  logic [7:0] mw [16];
  logic       mp;
  logic [7:0] ed;
  logic [3:0] et;
  logic       ep;
  logic [7:0] mask_tab [23] = '{8'h80, 8'h3F, 8'h00, 8'hFF, 8'hBF, 8'hFF, 8'h3F, 8'h00, 8'hFF, 8'hBF,
                                8'h7F, 8'hFF, 8'h9F, 8'hFF, 8'hBF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hBF,
                                8'h00, 8'h00, 8'h70};
  gb_sound_regs #(.WAVE_INIT(WINIT)) dut (
    .clock(clk), .reset(rst), .addr(addr), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(data_out), .ch_active(ch_active), .regs_out(regs_out), .wave_out(wave_out),
    .trig(trig), .power_on(power_on)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [183:0] got, input logic [183:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] model_read(input int a, input logic [3:0] ch);
    if (a < 22) return (mp ? m[a] : 8'h00) | mask_tab[a];
    if (a == 22) return {mp, 3'b111, ch & {4{mp}}};
    if (a >= 32 && a < 48) return mw[a-32];
    return 8'hFF;
  endfunction
  function automatic logic [183:0] model_regs();
    logic [183:0] v = '0;
    for (int n = 0; n < 22; n++) v[8*n +: 8] = mp ? m[n] : 8'h00;
    v[183] = mp;
    return v;
  endfunction
  function automatic logic [127:0] model_wave();
    logic [127:0] v;
    for (int n = 0; n < 16; n++) v[8*n +: 8] = mw[n];
    return v;
  endfunction
  task automatic model_reset();
    for (int n = 0; n < 22; n++) m[n] = 8'h00;
    for (int n = 0; n < 16; n++) mw[n] = WINIT[8*n +: 8];
    mp = 1'b0; ed = 8'h00; et = 4'h0; ep = 1'b0;
  endtask
  task automatic cyc(input logic r, input logic w, input logic rv, input int a, input logic [7:0] d, input logic [3:0] ch);
    rst = r; wr = w; rd = rv; addr = 6'(a); data_in = d; ch_active = ch;
    @(posedge clk);
    if (r) model_reset();
    else begin
      et = 4'h0; ep = 1'b0;
      if (rv) ed = model_read(a, ch);
      if (w) begin
        if (a == 22) begin
          if (mp && !d[7]) for (int n = 0; n < 22; n++) m[n] = 8'h00;
          if (!mp && d[7]) ep = 1'b1;
          mp = d[7];
        end else if (a >= 32 && a < 48) mw[a-32] = d;
        else if (a < 22 && mp && a != 5 && a != 15) begin
          m[a] = d;
          if (a % 5 == 4 && d[7]) et[a/5] = 1'b1;
        end
      end
    end
    #1;
    chk("data_out", 184'(data_out), 184'(ed));
    chk("regs_out", regs_out, model_regs());
    chk("wave_out", 184'(wave_out), 184'(model_wave()));
    chk("trig", 184'(trig), 184'(et));
    chk("power_on", 184'(power_on), 184'(ep));
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask
  initial begin
    model_reset();
    cyc(1, 0, 0, 0, 8'h00, 4'h0);
    cyc(0, 0, 1, 22, 8'h00, 4'h0);
    chk("rst_nr52_read", 184'(data_out), 184'h70);
    cyc(0, 0, 1, 0, 8'h00, 4'h0);
    chk("rst_nr10_read", 184'(data_out), 184'h80);
    chk("rst_regs_out", regs_out, 184'h0);
    cyc(0, 1, 0, 22, 8'h80, 4'h0);
    chk("pon_pulse", 184'(power_on), 184'h1);
    cyc(0, 0, 0, 0, 8'h00, 4'h0);
    chk("pon_one_cycle", 184'(power_on), 184'h0);
    cyc(0, 1, 0, 1, 8'hC5, 4'h0);
    cyc(0, 0, 1, 1, 8'h00, 4'h0);
    chk("nr11_read", 184'(data_out), 184'hFF);
    chk("nr11_stored", 184'(regs_out[15:8]), 184'hC5);
    cyc(0, 1, 0, 4, 8'h87, 4'b0101);
    chk("trig_ch1", 184'(trig), 184'h1);
    cyc(0, 0, 1, 22, 8'h00, 4'b0101);
    chk("trig_clear", 184'(trig), 184'h0);
    chk("nr52_status", 184'(data_out), 184'hF5);
    cyc(0, 0, 1, 4, 8'h00, 4'b0101);
    chk("nr14_read", 184'(data_out), 184'hBF);
    cyc(0, 1, 0, 20, 8'h77, 4'h0);
    cyc(0, 1, 0, 21, 8'hF3, 4'h0);
    cyc(0, 1, 0, 22, 8'h00, 4'h0);
    chk("poweroff_clear", 184'(regs_out[175:0]), 184'h0);
    cyc(0, 0, 1, 20, 8'h00, 4'h0);
    chk("nr50_off_read", 184'(data_out), 184'h00);
    cyc(0, 0, 1, 22, 8'h00, 4'hF);
    chk("nr52_off_read", 184'(data_out), 184'h70);
    cyc(0, 1, 0, 20, 8'h55, 4'h0);
    chk("off_write_ignored", 184'(regs_out[167:160]), 184'h0);
    cyc(0, 1, 0, 19, 8'h80, 4'h0);
    chk("off_no_trig", 184'(trig), 184'h0);
    cyc(0, 1, 0, 37, 8'hA9, 4'h0);
    chk("wave_write_off", 184'(wave_out[47:40]), 184'hA9);
    cyc(0, 0, 1, 37, 8'h00, 4'h0);
    chk("wave_read", 184'(data_out), 184'hA9);
    cyc(0, 0, 1, 26, 8'h00, 4'h0);
    chk("unmapped_read", 184'(data_out), 184'hFF);
    cyc(0, 1, 0, 22, 8'h80, 4'h0);
    cyc(0, 1, 0, 22, 8'h80, 4'h0);
    chk("repower_no_pulse", 184'(power_on), 184'h0);
    cyc(0, 1, 1, 2, 8'hF0, 4'h0);
    cyc(0, 1, 1, 2, 8'h0F, 4'h0);
    chk("rd_wr_prewrite", 184'(data_out), 184'hF0);
    cyc(0, 1, 0, 9, 8'h80, 4'h0);
    cyc(1, 1, 0, 2, 8'hF0, 4'h0);
    chk("reset_wins_byte2", 184'(regs_out[23:16]), 184'h0);
    chk("reset_power", 184'(regs_out[183]), 184'h0);
    chk("reset_trig", 184'({trig, power_on}), 184'h0);
    for (int i = 0; i < 3000; i++) begin
      int a;
      logic [7:0] d;
      d = 8'($urandom);
      a = ($urandom_range(0, 15) == 0) ? 22 : $urandom_range(0, 47);
      if (a == 22 && $urandom_range(0, 3) != 0) d[7] = 1'b1;
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
          a, d, 4'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
